booth_acc: RTL
==============

BOOTH_ACC -- requirements
Module: booth_acc

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning the number of products per frame (legal 1..255).
REQ-002 SHALL have parameter ACC_W, default 16, meaning the accumulator width in bits (legal 9..32).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port prod_in  input  8  signed two's-complement product from the upstream 4x4 Booth multiplier.
REQ-006 SHALL have port prod_valid  input  1  prod_in holds a valid product.
REQ-007 SHALL have port prod_ready  output  1  the block can accept a product this cycle.
REQ-008 SHALL have port clear  input  1  synchronous frame abort.
REQ-009 SHALL have port acc_out  output  ACC_W  signed frame sum.
REQ-010 SHALL have port acc_valid  output  1  acc_out holds a completed frame sum.
REQ-011 SHALL have port acc_ready  input  1  downstream accepts acc_out.
REQ-012 SHALL have port ovf  output  1  at least one signed overflow occurred in the current or held frame (sticky).

Function
REQ-013 SHALL implement two states: ACC (collecting products) and OUT (holding the result).
REQ-014 SHALL drive prod_ready = 1 in ACC and 0 in OUT.
REQ-015 SHALL accept a product when prod_valid && prod_ready: acc <= acc + sign-extended prod_in, cnt <= cnt + 1.
REQ-016 SHALL move to OUT on the cycle after the LEN-th accepted product, with acc_valid = 1 and acc_out = final sum; this is 1-cycle latency.
REQ-017 SHALL keep acc_out, acc_valid and ovf stable in OUT while acc_ready = 0.
REQ-018 SHALL, in OUT with acc_ready = 1, return to ACC next cycle with acc = 0, cnt = 0, ovf = 0 and acc_valid = 0.
REQ-019 SHALL NOT accept a product in the same cycle as the result handshake; the first product of the next frame is accepted no earlier than the following cycle.
REQ-020 SHALL ignore prod_in and prod_valid while in OUT.
REQ-021 SHALL detect signed overflow when the exact sum of acc and the extended product does not fit in ACC_W bits, and SHALL set ovf.
REQ-022 SHALL give clear priority over acceptance and over the result handshake: next cycle it forces state = ACC, acc = 0, cnt = 0, ovf = 0, acc_valid = 0, and discards any product presented that cycle.
REQ-023 SHALL, when LEN = 1, enter OUT after every single accepted product.

Reset
REQ-024 SHALL, while rst_n = 0, asynchronously force state = ACC, acc = 0, cnt = 0, acc_out = 0, acc_valid = 0, ovf = 0 and prod_ready = 0.
REQ-025 SHALL have prod_ready = 1 on the first clk edge after rst_n deasserts.
REQ-026 SHALL, on reset mid-frame or in OUT, discard all partial or held results without producing any handshake.

Configuration
REQ-027 SHALL, with BOOTH_ACC_SAT_EN defined, saturate acc on overflow to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)) and keep saturating on further overflows; ovf is still set.
REQ-028 SHALL, without BOOTH_ACC_SAT_EN, wrap acc modulo 2^ACC_W; ovf is still set.

Verification
REQ-029 SHALL cover: LEN=4, products 0x0A,0x14,0x1E,0x28 back-to-back -> acc_out=0x0064, acc_valid one cycle after the 4th accept, ovf=0.
REQ-030 SHALL cover: LEN=4, products 0x06,0xF4,0x07,0xFF -> acc_out=0x0000; products 0x80 x4 -> acc_out=0xFE00.
REQ-031 SHALL cover: ACC_W=10, LEN=8, eight products of 0x7F -> with BOOTH_ACC_SAT_EN acc_out=0x1FF and ovf=1; without it acc_out=0x3F8 and ovf=1.
REQ-032 SHALL cover: acc_ready held low 3 cycles in OUT with prod_valid=1 -> acc_out stable, prod_ready=0, no product consumed; release -> ACC next cycle with acc=0.
REQ-033 SHALL cover: clear pulsed after 2 accepts, then clear pulsed in OUT -> no acc_valid for the aborted frame, result dropped, and the next frame sums from 0.
REQ-034 SHALL cover: rst_n pulsed low mid-clock during a frame -> outputs zero immediately with no clk edge needed, and the next frame gives the correct sum.

Source files
------------

// File: rtl/booth_acc.sv
// Frame accumulator for signed 8-bit Booth products: sums LEN products, then holds the result until acc_ready.
// Build option: define BOOTH_ACC_SAT_EN to saturate on overflow; otherwise the accumulator wraps.
//
//   state | meaning
//   ------+------------------------------------------------
//   ACC   | collecting products, prod_ready high
//   OUT   | frame sum held on acc_out, acc_valid high
module booth_acc #(
   parameter int LEN   = 4,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       prod_in,
   input  logic             prod_valid,
   output logic             prod_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             ovf
);

   typedef enum logic {ACC, OUT} state_t;

   localparam logic [7:0]       LAST    = 8'(LEN - 1);
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             live_q, live_d;

   logic [ACC_W:0]   sum_ext;
   logic             sum_ovf;
   logic [ACC_W-1:0] sum_fix;
   logic             accept;

   // live_q keeps prod_ready low for the whole reset and up to the first edge after release
   assign prod_ready = live_q && (state_q == ACC);
   assign accept     = prod_valid && prod_ready;
   assign acc_out    = acc_q;
   assign acc_valid  = (state_q == OUT);
   assign ovf        = ovf_q;

   // one guard bit makes the exact sum visible; overflow when guard and sign disagree
   always_comb begin
      sum_ext = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){prod_in[7]}}, prod_in};
      sum_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
`ifdef BOOTH_ACC_SAT_EN
      if (sum_ovf)
         sum_fix = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
      else
         sum_fix = sum_ext[ACC_W-1:0];
`else
      sum_fix = sum_ext[ACC_W-1:0];
`endif
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      live_d  = 1'b1;
      if (clear) begin
         state_d = ACC;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (accept) begin
                  acc_d = sum_fix;
                  ovf_d = ovf_q | sum_ovf;
                  if (cnt_q == LAST) begin
                     cnt_d   = '0;
                     state_d = OUT;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            OUT: begin
               if (acc_ready) begin
                  state_d = ACC;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         live_q  <= live_d;
      end
   end

endmodule
